// File: rtl/ntt_k2_wb_agu.sv
// ntt_k2_wb_agu: write-back address generator for the last NTT stage (k2).
//
// Each 16-lane group of butterfly order pairs (Order_0/Order_1) issued by the
// read-side AGU is captured into a tag FIFO. The FIFO holds the groups while
// the butterfly pipeline runs. As each result group leaves the butterfly array,
// the captured pairs are replayed in issue order as memory write addresses.
// wb_done rises once NUM_GROUPS groups have been written back.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   wb_enable            stage active; low clears everything back to IDLE
//   addr_valid           AGU group valid; order0_in/order1_in hold the packed pairs
//   res_valid            butterfly result group valid; pops one group
//   wr_en                write strobe, one cycle after the pop
//   wr_addr0/wr_addr1    replayed write addresses; held while wr_en is low
//   fifo_full/empty      occupancy flags
//   overflow/underflow   sticky error flags (dropped push / pop on empty)
//   wb_done              level, all groups of the stage written back
module ntt_k2_wb_agu #(
  parameter int D_WIDTH    = 12,
  parameter int LANES      = 16,
  parameter int DEPTH      = 8,
  parameter int NUM_GROUPS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_enable,
  input  logic                     addr_valid,
  input  logic [LANES*D_WIDTH-1:0] order0_in,
  input  logic [LANES*D_WIDTH-1:0] order1_in,
  input  logic                     res_valid,
  output logic                     wr_en,
  output logic [LANES*D_WIDTH-1:0] wr_addr0,
  output logic [LANES*D_WIDTH-1:0] wr_addr1,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     wb_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(NUM_GROUPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   wptr, rptr;
  logic [OW-1:0]   occ;
  logic [CW-1:0]   cnt;
  logic            run, clr, push, pop, last_pop;

  assign fifo_full  = (occ == OW'(DEPTH));
  assign fifo_empty = (occ == '0);
  assign wb_done    = (state == DONE);

  // Inputs are only honoured in RUN with the stage still enabled; a low
  // wb_enable discards this cycle's traffic because everything clears anyway.
  assign run      = (state == RUN) && wb_enable;
  assign clr      = !wb_enable || (state == IDLE);
  assign pop      = run && res_valid && !fifo_empty;
  // A full FIFO still accepts a push when a pop frees the slot this cycle.
  assign push     = run && addr_valid && (!fifo_full || pop);
  assign last_pop = pop && (cnt == CW'(NUM_GROUPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!wb_enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     if (last_pop) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      occ       <= '0;
      cnt       <= '0;
      wr_en     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      occ       <= '0;
      cnt       <= '0;
      wr_en     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_en <= pop;
      // DEPTH is a power of two, so pointer wrap is the natural rollover.
      if (push) wptr <= wptr + PW'(1);
      if (pop) begin
        rptr <= rptr + PW'(1);
        cnt  <= cnt + CW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
      if (run && addr_valid && !push) overflow <= 1'b1;
      // No bypass: emptiness is judged at the start of the cycle.
      if (run && res_valid && fifo_empty) underflow <= 1'b1;
    end
  end

  // Per-lane tag storage and registered replay. When full with a simultaneous
  // push/pop, wptr==rptr; the read sees the old entry since the write lands at
  // the same edge.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [D_WIDTH-1:0] mem0 [DEPTH];
    logic [D_WIDTH-1:0] mem1 [DEPTH];
    logic [D_WIDTH-1:0] a0, a1;

    always_ff @(posedge clk) begin
      if (push) begin
        mem0[wptr] <= order0_in[i*D_WIDTH +: D_WIDTH];
        mem1[wptr] <= order1_in[i*D_WIDTH +: D_WIDTH];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a0 <= '0;
        a1 <= '0;
      end else if (clr) begin
        a0 <= '0;
        a1 <= '0;
      end else if (pop) begin
        a0 <= mem0[rptr];
        a1 <= mem1[rptr];
      end
    end

    assign wr_addr0[i*D_WIDTH +: D_WIDTH] = a0;
    assign wr_addr1[i*D_WIDTH +: D_WIDTH] = a1;
  end

endmodule

// File: tb/tb_ntt_k2_wb_agu.sv
// Testbench for ntt_k2_wb_agu: a queue scoreboard receives every accepted
// group and is drained on each predicted write-back; a monitor compares all
// outputs on the falling edge, and directed checks cover the boundary cases.
module tb_ntt_k2_wb_agu;
  localparam int DW  = 12;
  localparam int L   = 16;
  localparam int DEP = 8;
  localparam int NG  = 16;
  localparam int W   = L * DW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wb_enable = 1'b0;
  logic         addr_valid = 1'b0;
  logic         res_valid = 1'b0;
  logic [W-1:0] order0_in = '0;
  logic [W-1:0] order1_in = '0;
  logic         wr_en, fifo_full, fifo_empty, overflow, underflow, wb_done;
  logic [W-1:0] wr_addr0, wr_addr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ntt_k2_wb_agu #(.D_WIDTH(DW), .LANES(L), .DEPTH(DEP), .NUM_GROUPS(NG)) dut (
    .clk(clk), .rst(rst), .wb_enable(wb_enable), .addr_valid(addr_valid),
    .order0_in(order0_in), .order1_in(order1_in), .res_valid(res_valid),
    .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow),
    .underflow(underflow), .wb_done(wb_done)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard and reference state.
  typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;
  mst_t         ms = M_IDLE;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           m_cnt = 0;
  bit           m_wr = 0, m_ovf = 0, m_unf = 0, m_full = 0, m_pop = 0;
  logic [W-1:0] m_a0 = '0, m_a1 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst || !wb_enable || ms == M_IDLE) begin
      ms    = (!rst && wb_enable) ? M_RUN : M_IDLE;
      q0.delete();
      q1.delete();
      m_cnt = 0;
      m_wr  = 0;
      m_ovf = 0;
      m_unf = 0;
      m_a0  = '0;
      m_a1  = '0;
    end else if (ms == M_RUN) begin
      m_full = (q0.size() == DEP);
      m_pop  = res_valid && (q0.size() > 0);
      m_wr   = m_pop;
      if (res_valid && !m_pop) m_unf = 1;
      if (m_pop) begin
        m_a0 = q0.pop_front();
        m_a1 = q1.pop_front();
        m_cnt++;
        if (m_cnt == NG) ms = M_DONE;
      end
      if (addr_valid) begin
        if (!m_full || m_pop) begin
          q0.push_back(order0_in);
          q1.push_back(order1_in);
        end else begin
          m_ovf = 1;
        end
      end
    end else begin
      m_wr = 0;
    end
  end

  int                wr_cnt = 0;
  logic [DW-1:0]     obs_l0[$];

  always @(negedge clk) begin
    chk("wr_en",      W'(wr_en),      W'(m_wr));
    chk("wr_addr0",   wr_addr0,       m_a0);
    chk("wr_addr1",   wr_addr1,       m_a1);
    chk("fifo_full",  W'(fifo_full),  W'(q0.size() == DEP));
    chk("fifo_empty", W'(fifo_empty), W'(q0.size() == 0));
    chk("overflow",   W'(overflow),   W'(m_ovf));
    chk("underflow",  W'(underflow),  W'(m_unf));
    chk("wb_done",    W'(wb_done),    W'(ms == M_DONE));
    if (wr_en) begin
      wr_cnt++;
      obs_l0.push_back(wr_addr0[DW-1:0]);
    end
  end

  function automatic logic [W-1:0] rnd_grp();
    logic [W-1:0] r;
    for (int i = 0; i < L; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic step(input bit av, input bit rv, input logic [W-1:0] o0, input logic [W-1:0] o1);
    addr_valid = av;
    res_valid  = rv;
    order0_in  = o0;
    order1_in  = o1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic start();
    wb_enable = 1'b1;
    idle(1);
  endtask

  task automatic stop();
    wb_enable = 1'b0;
    idle(1);
  endtask

  logic [W-1:0] g0, g1;

  initial begin
    #1;
    chk("rst_wr_en",  W'(wr_en),      W'(0));
    chk("rst_empty",  W'(fifo_empty), W'(1));
    chk("rst_full",   W'(fifo_full),  W'(0));
    chk("rst_done",   W'(wb_done),    W'(0));
    chk("rst_addr0",  wr_addr0,       '0);
    idle(2);
    rst = 1'b0;

    // Reset mid-RUN with 3 groups queued.
    start();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, rnd_grp(), rnd_grp());
    chk("t1_occupied", W'(fifo_empty), W'(0));
    rst = 1'b1;
    #1;
    chk("t1_wr_en",  W'(wr_en),      W'(0));
    chk("t1_empty",  W'(fifo_empty), W'(1));
    chk("t1_ovf",    W'(overflow),   W'(0));
    chk("t1_unf",    W'(underflow),  W'(0));
    chk("t1_done",   W'(wb_done),    W'(0));
    wb_enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Ordered replay of 4 groups.
    start();
    obs_l0.delete();
    for (int k = 0; k < 4; k++) begin
      g0 = rnd_grp();
      g1 = rnd_grp();
      g0[DW-1:0] = DW'(2 * k);
      g1[DW-1:0] = DW'(100 + k);
      step(1'b1, 1'b0, g0, g1);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, '0, '0);
    idle(1);
    chk("t2_nwr", W'(obs_l0.size()), W'(4));
    for (int k = 0; k < 4 && k < obs_l0.size(); k++)
      chk("t2_lane0", W'(obs_l0[k]), W'(2 * k));
    stop();

    // Full, overflow drop, push+pop while full.
    start();
    for (int k = 0; k < DEP; k++) step(1'b1, 1'b0, rnd_grp(), rnd_grp());
    chk("t3_full", W'(fifo_full), W'(1));
    step(1'b1, 1'b0, rnd_grp(), rnd_grp());
    chk("t3_ovf",   W'(overflow),  W'(1));
    chk("t3_full2", W'(fifo_full), W'(1));
    step(1'b1, 1'b1, rnd_grp(), rnd_grp());
    chk("t3_full3", W'(fifo_full), W'(1));
    chk("t3_wr",    W'(wr_en),     W'(1));
    for (int k = 0; k < DEP; k++) step(1'b0, 1'b1, '0, '0);
    chk("t3_drained", W'(fifo_empty), W'(1));
    stop();

    // Underflow, then push+res_valid on empty.
    start();
    step(1'b0, 1'b1, '0, '0);
    chk("t4_unf", W'(underflow), W'(1));
    chk("t4_wr",  W'(wr_en),     W'(0));
    stop();
    start();
    step(1'b1, 1'b1, rnd_grp(), rnd_grp());
    chk("t4_unf2",  W'(underflow),  W'(1));
    chk("t4_occ1",  W'(fifo_empty), W'(0));
    chk("t4_wr2",   W'(wr_en),      W'(0));
    stop();

    // Full stage with 3-cycle butterfly lag.
    start();
    wr_cnt = 0;
    for (int t = 0; t < 19; t++) step(t < 16, t >= 3, rnd_grp(), rnd_grp());
    chk("t5_last_wr", W'(wr_en),   W'(1));
    chk("t5_done",    W'(wb_done), W'(1));
    idle(1);
    chk("t5_pulses",  W'(wr_cnt),  W'(16));
    chk("t5_hold",    W'(wb_done), W'(1));
    wb_enable = 1'b0;
    idle(1);
    chk("t5_clear",   W'(wb_done), W'(0));

    // Pointer wrap at steady occupancy 2.
    start();
    for (int k = 0; k < 2; k++) step(1'b1, 1'b0, rnd_grp(), rnd_grp());
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, rnd_grp(), rnd_grp());
    for (int k = 0; k < 2; k++) step(1'b0, 1'b1, '0, '0);
    idle(1);
    chk("t6_ovf",  W'(overflow),  W'(0));
    chk("t6_unf",  W'(underflow), W'(0));
    chk("t6_done", W'(wb_done),   W'(1));
    stop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
